// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared constants, FSM encoding and the double-dabble nibble adjust helper
// for the VGA coordinate scheduler.
// -----------------------------------------------------------------------------
package vga_text_pkg;

    localparam int COORD_W   = 10;
    localparam int BCD_W     = 12;
    localparam int SCRATCH_W = BCD_W + COORD_W;

    // Line number of the first vertical-blanking line
    localparam logic [9:0]         VBLANK_LINE = 10'd480;
    // Largest value that still fits in three BCD digits
    localparam logic [COORD_W-1:0] MAX_VAL     = 10'd999;

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Double-dabble correction: a digit of 5 or more gets 3 added so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Unsigned saturation to the three-digit range
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v);
        logic [COORD_W-1:0] res;
        if (v > MAX_VAL) begin
            res = MAX_VAL;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// -----------------------------------------------------------------------------
// bcd_dd_step
// One combinational double-dabble iteration on the scratch register
// {hundreds, tens, ones, binary}: adjust each BCD digit, then shift left by 1.
// Ports:
//   i_scratch  scratch value before this iteration
//   o_scratch  scratch value after adjust + shift
// -----------------------------------------------------------------------------
module bcd_dd_step
    import vga_text_pkg::*;
(
    input  logic [SCRATCH_W-1:0] i_scratch,
    output logic [SCRATCH_W-1:0] o_scratch
);

    logic [SCRATCH_W-1:0] w_adj;

    // Adjust the three BCD digits above the binary field, then shift
    always_comb begin
        w_adj = i_scratch;
        for (int j = 0; j < 3; j++) begin
            w_adj[COORD_W + 4*j +: 4] = dd_adjust(i_scratch[COORD_W + 4*j +: 4]);
        end
        o_scratch = {w_adj[SCRATCH_W-2:0], 1'b0};
    end

endmodule

// File: rtl/vga_coord_scheduler.sv
// -----------------------------------------------------------------------------
// vga_coord_scheduler
// Captures x/y/z once per frame at the start of vertical blanking, clamps them
// to 0..999, converts each to 3-digit BCD with one shared double-dabble step
// (one channel at a time) and publishes all nine digits in a single cycle.
// Ports:
//   clk, rst_n        pixel clock, synchronous active-low reset
//   counterY          current line from the sync generator
//   freeze            skip capture this frame (published digits hold)
//   x/y/z_coord       coordinate inputs
//   x/y/z_bcd         published {hundreds,tens,ones}
//   digits_valid      one-cycle pulse on publish
//   busy              conversion in flight
//   overrun           sticky: vblank edge seen while not idle
// -----------------------------------------------------------------------------
module vga_coord_scheduler
    import vga_text_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         counterY,
    input  logic               freeze,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic [COORD_W-1:0] z_coord,
    output logic [BCD_W-1:0]   x_bcd,
    output logic [BCD_W-1:0]   y_bcd,
    output logic [BCD_W-1:0]   z_bcd,
    output logic               digits_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [3:0] BIT_LAST = 4'(COORD_W - 1);

    logic [1:0]           r_state;
    logic                 r_line_hit_q;
    logic [1:0]           r_ch;
    logic [3:0]           r_bit_cnt;
    logic [SCRATCH_W-1:0] r_scratch;
    logic [COORD_W-1:0]   r_snap_x, r_snap_y, r_snap_z;
    logic [BCD_W-1:0]     r_pend_x, r_pend_y, r_pend_z;
    logic [BCD_W-1:0]     r_x_bcd, r_y_bcd, r_z_bcd;
    logic                 r_digits_valid, r_busy, r_overrun;

    logic                 w_hit;
    logic                 w_vb_edge;
    logic [COORD_W-1:0]   w_snap_sel;
    logic [SCRATCH_W-1:0] w_step;

    assign w_hit     = (counterY == VBLANK_LINE);
    assign w_vb_edge = w_hit & ~r_line_hit_q;

    // Select the snapshot of the channel being loaded
    always_comb begin
        w_snap_sel = {COORD_W{1'b0}};
        case (r_ch)
            2'd0:    w_snap_sel = r_snap_x;
            2'd1:    w_snap_sel = r_snap_y;
            2'd2:    w_snap_sel = r_snap_z;
            default: w_snap_sel = {COORD_W{1'b0}};
        endcase
    end

    bcd_dd_step u_step (
        .i_scratch (r_scratch),
        .o_scratch (w_step)
    );

    // Scheduler FSM, conversion datapath and published outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_line_hit_q   <= 1'b0;
            r_ch           <= 2'd0;
            r_bit_cnt      <= 4'd0;
            r_scratch      <= {SCRATCH_W{1'b0}};
            r_snap_x       <= {COORD_W{1'b0}};
            r_snap_y       <= {COORD_W{1'b0}};
            r_snap_z       <= {COORD_W{1'b0}};
            r_pend_x       <= {BCD_W{1'b0}};
            r_pend_y       <= {BCD_W{1'b0}};
            r_pend_z       <= {BCD_W{1'b0}};
            r_x_bcd        <= {BCD_W{1'b0}};
            r_y_bcd        <= {BCD_W{1'b0}};
            r_z_bcd        <= {BCD_W{1'b0}};
            r_digits_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_line_hit_q   <= w_hit;
            r_digits_valid <= 1'b0;
            // A new frame arriving before the previous one is published
            // is only flagged; the running conversion is left untouched.
            if (w_vb_edge && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_vb_edge && !freeze) begin
                        r_snap_x <= clamp_coord(x_coord);
                        r_snap_y <= clamp_coord(y_coord);
                        r_snap_z <= clamp_coord(z_coord);
                        r_ch     <= 2'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_scratch <= {{BCD_W{1'b0}}, w_snap_sel};
                    r_bit_cnt <= 4'd0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_scratch <= w_step;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == BIT_LAST) begin
                        case (r_ch)
                            2'd0:    r_pend_x <= w_step[SCRATCH_W-1:COORD_W];
                            2'd1:    r_pend_y <= w_step[SCRATCH_W-1:COORD_W];
                            default: r_pend_z <= w_step[SCRATCH_W-1:COORD_W];
                        endcase
                        if (r_ch == 2'd2) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_ch    <= r_ch + 2'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_x_bcd        <= r_pend_x;
                    r_y_bcd        <= r_pend_y;
                    r_z_bcd        <= r_pend_z;
                    r_digits_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_bcd        = r_x_bcd;
    assign y_bcd        = r_y_bcd;
    assign z_bcd        = r_z_bcd;
    assign digits_valid = r_digits_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_vga_coord_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_coord_scheduler
// Self-checking bench: a frame-level model (capture, count 34 clocks, publish
// decimal digits computed with / and %) is compared against the DUT on every
// cycle, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_vga_coord_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  counterY;
    logic        freeze;
    logic [9:0]  x_coord, y_coord, z_coord;
    logic [11:0] x_bcd, y_bcd, z_bcd;
    logic        digits_valid, busy, overrun;

    vga_coord_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .counterY     (counterY),
        .freeze       (freeze),
        .x_coord      (x_coord),
        .y_coord      (y_coord),
        .z_coord      (z_coord),
        .x_bcd        (x_bcd),
        .y_bcd        (y_bcd),
        .z_bcd        (z_bcd),
        .digits_valid (digits_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int dv_seen  = 0;
    int busy_seen = 0;

    // Reference model state
    bit          m_hit_q;
    int          m_age;        // -1 idle, else clocks since capture
    int          m_snap [3];
    logic [11:0] m_bcd [3];
    bit          m_dv, m_ovr;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic int clampv(input int v);
        return (v > 999) ? 999 : v;
    endfunction

    task automatic model_reset();
        m_hit_q = 1'b0;
        m_age   = -1;
        m_dv    = 1'b0;
        m_ovr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_snap[i] = 0;
            m_bcd[i]  = 12'h000;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit hit, edge_s;
        if (!rst_n) begin
            model_reset();
        end else begin
            hit     = (counterY == 10'd480);
            edge_s  = hit && !m_hit_q;
            m_hit_q = hit;
            m_dv    = 1'b0;
            if (m_age >= 0) begin
                if (edge_s) m_ovr = 1'b1;
                m_age++;
                if (m_age == 34) begin
                    for (int i = 0; i < 3; i++) m_bcd[i] = to_bcd(m_snap[i]);
                    m_dv  = 1'b1;
                    m_age = -1;
                end
            end else if (edge_s && !freeze) begin
                m_snap[0] = clampv(int'(x_coord));
                m_snap[1] = clampv(int'(y_coord));
                m_snap[2] = clampv(int'(z_coord));
                m_age     = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic compare_all();
        chk("x_bcd", 32'(x_bcd), 32'(m_bcd[0]));
        chk("y_bcd", 32'(y_bcd), 32'(m_bcd[1]));
        chk("z_bcd", 32'(z_bcd), 32'(m_bcd[2]));
        chk("digits_valid", 32'(digits_valid), 32'(m_dv));
        chk("busy", 32'(busy), 32'(m_age >= 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (digits_valid === 1'b1) dv_seen++;
        if (busy === 1'b1) busy_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_xyz(input int x, input int y, input int z);
        x_coord = 10'(x);
        y_coord = 10'(y);
        z_coord = 10'(z);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; counterY = 10'd0; freeze = 1'b0;
        set_xyz(0, 0, 0);
        steps(3);
        chk("reset_x_bcd", 32'(x_bcd), 32'h000);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        steps(2);

        // Pin the model's digit arithmetic
        chk("model_bcd_123", 32'(to_bcd(123)), 32'h123);
        chk("model_bcd_clamp", 32'(to_bcd(clampv(1023))), 32'h999);

        // Basic conversion and latency
        set_xyz(123, 456, 789);
        counterY = 10'd479; steps(2);
        counterY = 10'd480; dv_seen = 0; busy_seen = 0;
        step();                       // edge k
        steps(33);                    // through k+33
        chk("t1_busy_cycles", 32'(busy_seen), 32'd34);
        chk("t1_no_early_dv", 32'(dv_seen), 32'd0);
        step();                       // k+34
        chk("t1_x", 32'(x_bcd), 32'h123);
        chk("t1_y", 32'(y_bcd), 32'h456);
        chk("t1_z", 32'(z_bcd), 32'h789);
        chk("t1_dv", 32'(digits_valid), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        step();
        chk("t1_dv_one_cycle", 32'(digits_valid), 32'd0);

        // Clamp and zero
        counterY = 10'd0; step();
        set_xyz(1023, 0, 999);
        counterY = 10'd480; steps(35);
        chk("t2_x", 32'(x_bcd), 32'h999);
        chk("t2_y", 32'(y_bcd), 32'h000);
        chk("t2_z", 32'(z_bcd), 32'h999);

        // Input change after capture does not leak into the result
        counterY = 10'd0; step();
        set_xyz(123, 1, 2);
        counterY = 10'd480; step();
        steps(5);
        x_coord = 10'd500;
        steps(29);
        chk("t3_x_held", 32'(x_bcd), 32'h123);
        counterY = 10'd0; step();
        counterY = 10'd480; steps(35);
        chk("t3_x_next", 32'(x_bcd), 32'h500);

        // Freeze skips the frame; a long hold gives one publish
        counterY = 10'd0; step();
        set_xyz(77, 88, 99);
        freeze = 1'b1; dv_seen = 0; busy_seen = 0;
        counterY = 10'd479; step();
        counterY = 10'd480; steps(40);
        chk("t4_freeze_dv", 32'(dv_seen), 32'd0);
        chk("t4_freeze_busy", 32'(busy_seen), 32'd0);
        chk("t4_freeze_x", 32'(x_bcd), 32'h500);
        freeze = 1'b0;
        counterY = 10'd0; step();
        counterY = 10'd480; dv_seen = 0; steps(800);
        chk("t4_hold_one_dv", 32'(dv_seen), 32'd1);
        chk("t4_hold_x", 32'(x_bcd), 32'h077);

        // Overrun while busy
        counterY = 10'd0; step();
        set_xyz(321, 654, 987);
        counterY = 10'd480; dv_seen = 0;
        step();                       // k
        steps(9);
        counterY = 10'd0; step();     // k+10
        counterY = 10'd480; step();   // k+11, edge while busy
        set_xyz(5, 6, 7);
        chk("t5_overrun_set", 32'(overrun), 32'd1);
        steps(22);                    // k+33
        step();                       // k+34
        chk("t5_x", 32'(x_bcd), 32'h321);
        chk("t5_z", 32'(z_bcd), 32'h987);
        chk("t5_dv", 32'(digits_valid), 32'd1);
        steps(40);
        chk("t5_single_publish", 32'(dv_seen), 32'd1);
        chk("t5_overrun_sticky", 32'(overrun), 32'd1);

        // Reset aborts a conversion
        counterY = 10'd0; step();
        counterY = 10'd480; step();
        steps(19);
        rst_n = 1'b0; counterY = 10'd0; dv_seen = 0;
        steps(2);
        chk("t6_x_zero", 32'(x_bcd), 32'h000);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        steps(40);
        chk("t6_no_dv", 32'(dv_seen), 32'd0);
        set_xyz(42, 900, 1000);
        counterY = 10'd480; steps(35);
        chk("t6_x_after", 32'(x_bcd), 32'h042);
        chk("t6_z_after", 32'(z_bcd), 32'h999);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       counterY = 10'd480;
                1:       counterY = 10'd479;
                2:       counterY = 10'd0;
                default: counterY = 10'($urandom_range(0, 1023));
            endcase
            freeze = ($urandom_range(0, 7) == 0);
            rst_n  = ($urandom_range(0, 499) != 0);
            set_xyz($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vga_coord_scheduler.md
Name: vga_coord_scheduler

Overview:
- Frame-synchronous scheduler between the robot-arm coordinate sources (x/y/z, 10-bit) and the VGA text renderer.
- Snapshots all three coordinates once per frame at the start of vertical blanking and clamps each to 0..999.
- Converts them to 3-digit BCD using a time-multiplexed double-dabble engine, one channel at a time.
- Publishes all digits atomically, so the renderer never shows torn values and needs no combinational divide/modulo.

Parameters:
- COORD_W, 10, coordinate input width.
- VBLANK_LINE, 480, counterY value that marks the start of vertical blanking.
- MAX_VAL, 999, saturation value applied before conversion.

Ports:
- clk  in  1  pixel clock (25 MHz domain of the sync generator)
- rst_n  in  1  synchronous reset, active-low
- counterY  in  10  current line from the sync generator
- freeze  in  1  1 = skip capture this frame; published digits hold
- x_coord  in  COORD_W  X coordinate
- y_coord  in  COORD_W  Y coordinate
- z_coord  in  COORD_W  Z coordinate
- x_bcd  out  12  {hundreds,tens,ones} of X
- y_bcd  out  12  BCD of Y
- z_bcd  out  12  BCD of Z
- digits_valid  out  1  one-cycle pulse when new digits are published
- busy  out  1  conversion in progress
- overrun  out  1  sticky: a vblank edge arrived while busy

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (rst_n).
- Reset (synchronous, rst_n=0 sampled at a clk edge):
  - state=IDLE.
  - x/y/z_bcd=12'h000, digits_valid=0, busy=0, overrun=0.
  - line_hit_q=0; snapshot and pending registers cleared.
  - Reset mid-conversion aborts it; no partial publish.
- Edge detect:
  - hit = (counterY==VBLANK_LINE); line_hit_q is hit registered.
  - vb_edge = hit & ~line_hit_q.
  - counterY held at VBLANK_LINE for many cycles produces one edge only.
- States: IDLE, LOAD, SHIFT, COMMIT.
- IDLE:
  - On vb_edge with freeze=0: snap[i] <= min(coord_i, MAX_VAL) for all three channels in the same edge; ch<=0; ->LOAD.
  - vb_edge with freeze=1 is ignored, with no flag.
- LOAD: scratch <= {12'b0, snap[ch]}; bit_cnt<=0; ->SHIFT.
- SHIFT (exactly COORD_W cycles):
  - Each cycle: every BCD nibble >=5 gets +3, then the 22-bit scratch shifts left by 1.
  - After the COORD_W-th shift: pending[ch] <= scratch[21:10].
  - If ch==2 ->COMMIT; else ch++ and ->LOAD.
- COMMIT:
  - x/y/z_bcd <= pending[0..2] in a single edge.
  - digits_valid=1 for exactly that one cycle.
  - ->IDLE.
- Latency:
  - vb_edge sampled at edge k: busy=1 from edge k through edge k+33; busy=0 and outputs/digits_valid updated at edge k+34.
  - Total 34 clocks: 3×(1 LOAD + 10 SHIFT) + 1 COMMIT. This is far below the vblank duration.
- Coordinate inputs that change after the capture edge do not affect the in-flight result.
- Overrun:
  - vb_edge while state != IDLE sets overrun=1. It stays set until reset.
  - The edge is otherwise ignored and the current conversion completes unchanged.
- Outputs change only at COMMIT or reset.
- Width rules:
  - Clamp compare is unsigned on COORD_W bits.
  - Nibble add-3 is 4-bit and never overflows because the input is <=999.

Decomposition:
- Package vga_text_pkg:
  - COORD_W, BCD_W=12, VBLANK_LINE, MAX_VAL.
  - State enum {IDLE, LOAD, SHIFT, COMMIT}.
  - SCRATCH_W = BCD_W + COORD_W.
- One sub-module, bcd_dd_step:
  - Purely combinational single double-dabble iteration.
  - 22-bit in, add-3 per nibble, shift left 1, 22-bit out.
  - Instantiated once and shared by all channels.

Test Plan:
- x=123, y=456, z=789; counterY 479→480 at edge k → at edge k+34: x_bcd=12'h123, y_bcd=12'h456, z_bcd=12'h789; digits_valid high exactly 1 cycle; busy high edges k..k+33.
- x=1023, y=0, z=999 → x_bcd=12'h999, y_bcd=12'h000, z_bcd=12'h999.
- Capture x=123, then change x to 500 at k+5 → published 12'h123; next frame's vblank publishes 12'h500.
- freeze=1 across the 479→480 transition → no busy, no digits_valid, outputs unchanged. counterY held at 480 for 800 cycles with freeze=0 → exactly one digits_valid pulse.
- Force counterY 480→0→480 at k+10 (while busy) → overrun=1 and stays 1; the first conversion publishes at k+34 with the original values; no second publish.
- rst_n=0 at k+20 for 2 cycles → all BCD outputs 000, busy=0, overrun=0, no digits_valid; the next vblank converts normally.
